// File: rtl/fn_pkg.sv
// Shared types and elaboration helpers for the iterative add/sub unit.
package fn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (width % chunk == 0);
  endfunction

  // clog2(n) with a floor of one bit so the degenerate single-chunk counter still exists
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fn_suma_chunk.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB
// so the caller can derive signed overflow on the final slice.
module fn_suma_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] tot;

  assign tot  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign s    = tot[CHUNK-1:0];
  assign cout = tot[CHUNK];
  // MSB sum bit = x ^ y ^ carry_in, so the carry into the MSB falls out without a second adder
  assign cmsb = s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/fn_suma_resta_iter.sv
// Multi-cycle add/sub: WIDTH/CHUNK cycles of RUN per op, one-cycle done pulse,
// start ignored while busy, result and flags held until the next completion.
module fn_suma_resta_iter
  import fn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resta,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("fn_suma_resta_iter: CHUNK must be >= 1 and divide WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] sum_c;
  logic             cout_c;
  logic             cmsb_c;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  fn_suma_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (op_a[CHUNK-1:0]),
    .y    (op_b[CHUNK-1:0]),
    .cin  (cy),
    .s    (sum_c),
    .cout (cout_c),
    .cmsb (cmsb_c)
  );

  // New chunk enters at the top; after N shifts the first chunk sits at bit 0
  assign acc_nxt = (acc >> CHUNK) | (WIDTH'(sum_c) << (WIDTH - CHUNK));
  assign last    = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Y        <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtraction as a + ~b + 1: the +1 rides in on the initial carry
            op_a  <= a;
            op_b  <= b ^ {WIDTH{resta}};
            cy    <= resta;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          op_a <= op_a >> CHUNK;
          op_b <= op_b >> CHUNK;
          acc  <= acc_nxt;
          cy   <= cout_c;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            Y        <= acc_nxt;
            carry    <= cout_c;
            overflow <= cmsb_c ^ cout_c;
            zero     <= (acc_nxt == '0);
            negative <= acc_nxt[WIDTH-1];
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
